// File: rtl/gf_red_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gf_red_pkg
//  Description : Shared definitions for the sequential GF(2) reducer.
//                FSM state encoding, pointer-width constant for the default
//                configuration, and the iteration-count helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package gf_red_pkg;

   localparam int DEF_DATA_WIDTH = 8;
   // Pointer into the 2*DATA_WIDTH working register (default configuration).
   localparam int PTR_W = $clog2(2 * DEF_DATA_WIDTH);

   typedef logic [1:0] state_t;
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   // Number of RUN cycles needed to clear positions 2*width-1 .. k,
   // DIGIT positions per cycle: ceil((2*width - k) / digit).
   function automatic int red_iters(input int width, input int k, input int digit);
      return (2 * width - k + digit - 1) / digit;
   endfunction

endpackage
`default_nettype wire

// File: rtl/gf_red_digit_step.sv
`default_nettype none
// ============================================================================
//  Module      : gf_red_digit_step
//  Description : Combinational reduction step. Walks DIGIT positions
//                downward from pointer p; for each position q >= k holding
//                a 1, XORs the modulus shifted up by (q - k) into R.
//  Ports       : i_r   working register in
//                i_p   highest position handled this step
//                i_mod modulus coefficients (bits above k ignored)
//                i_k   modulus degree
//                o_r   working register after the step
//  Revision    : 1.0 - initial release
// ============================================================================
module gf_red_digit_step #(
   parameter int DATA_WIDTH = 8,
   parameter int DIGIT      = 1,
   parameter int PW         = 4,
   parameter int KW         = 4
) (
   input  logic [2*DATA_WIDTH-1:0] i_r,
   input  logic [PW-1:0]           i_p,
   input  logic [DATA_WIDTH:0]     i_mod,
   input  logic [KW-1:0]           i_k,
   output logic [2*DATA_WIDTH-1:0] o_r
);

   localparam int RW = 2 * DATA_WIDTH;

   logic [RW-1:0] w_mod_ext;
   logic [RW-1:0] w_r;
   int            w_q;

   always_comb begin
      // Coefficients above the degree are don't-care on the input side.
      w_mod_ext = '0;
      for (int i = 0; i <= DATA_WIDTH; i++) begin
         if (i <= int'(i_k)) begin
            w_mod_ext[i] = i_mod[i];
         end
      end

      // Sequential dependence: each j sees the result of the previous XORs.
      w_r = i_r;
      w_q = 0;
      for (int j = 0; j < DIGIT; j++) begin
         w_q = int'(i_p) - j;
         if (w_q >= int'(i_k) && w_r[PW'(w_q)]) begin
            w_r = w_r ^ (w_mod_ext << (w_q - int'(i_k)));
         end
      end
   end

   assign o_r = w_r;

endmodule
`default_nettype wire

// File: rtl/gf_red_seq.sv
`default_nettype none
// ============================================================================
//  Module      : gf_red_seq
//  Description : Sequential GF(2) polynomial reducer with valid/ready on both
//                sides. Reduces a 2*DATA_WIDTH-bit value modulo a run-time
//                modulus of degree k, DIGIT positions per RUN cycle.
//  Ports       : clk, rst           clock, synchronous active-high reset
//                in_valid/in_ready  operand handshake
//                polyn_grade        modulus degree k
//                polyn_red_in       modulus coefficients
//                reduc_in           value to reduce
//                out_valid/out_ready result handshake
//                out, err           remainder, illegal-modulus flag
//                busy               reduction in progress
//  Revision    : 1.0 - initial release
// ============================================================================
module gf_red_seq
   import gf_red_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int DIGIT      = 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [$clog2(DATA_WIDTH):0]   polyn_grade,
   input  logic [DATA_WIDTH:0]           polyn_red_in,
   input  logic [2*DATA_WIDTH-1:0]       reduc_in,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [DATA_WIDTH-1:0]         out,
   output logic                          err,
   output logic                          busy
);

   localparam int RW = 2 * DATA_WIDTH;
   localparam int PW = $clog2(2 * DATA_WIDTH);
   localparam int KW = $clog2(DATA_WIDTH) + 1;
   localparam int CW = $clog2(2 * DATA_WIDTH + 1);

   state_t              r_state;
   logic [RW-1:0]       r_r;
   logic [PW-1:0]       r_p;
   logic [CW-1:0]       r_cnt;
   logic [CW-1:0]       r_n;
   logic [KW-1:0]       r_k;
   logic [DATA_WIDTH:0] r_mod;
   logic [DATA_WIDTH-1:0] r_out;
   logic                r_err;
   logic                r_valid;

   logic                w_legal;
   logic [CW-1:0]       w_n;
   logic [RW-1:0]       w_r_next;
   logic [PW-1:0]       w_p_next;

   always_comb begin
      w_legal = 1'b0;
      if (int'(polyn_grade) >= 2 && int'(polyn_grade) <= DATA_WIDTH) begin
         w_legal = polyn_red_in[polyn_grade];
      end
   end

   assign w_n = CW'(red_iters(DATA_WIDTH, int'(polyn_grade), DIGIT));

   // Pointer saturates at 0; once below k the step is a no-op anyway.
   assign w_p_next = (int'(r_p) >= DIGIT) ? PW'(int'(r_p) - DIGIT) : '0;

   gf_red_digit_step #(
      .DATA_WIDTH (DATA_WIDTH),
      .DIGIT      (DIGIT),
      .PW         (PW),
      .KW         (KW)
   ) u_step (
      .i_r   (r_r),
      .i_p   (r_p),
      .i_mod (r_mod),
      .i_k   (r_k),
      .o_r   (w_r_next)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_valid <= 1'b0;
         r_out   <= '0;
         r_err   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_k   <= polyn_grade;
                  r_mod <= polyn_red_in;
                  r_p   <= PW'(RW - 1);
                  r_cnt <= '0;
                  r_n   <= w_n;
                  if (w_legal) begin
                     r_r     <= reduc_in;
                     r_state <= S_RUN;
                  end else begin
                     // Illegal modulus: report immediately, R untouched.
                     r_out   <= '0;
                     r_err   <= 1'b1;
                     r_valid <= 1'b1;
                     r_state <= S_DONE;
                  end
               end
            end
            S_RUN: begin
               r_r   <= w_r_next;
               r_p   <= w_p_next;
               r_cnt <= r_cnt + CW'(1);
               if (r_cnt == r_n - CW'(1)) begin
                  r_out   <= w_r_next[DATA_WIDTH-1:0];
                  r_err   <= 1'b0;
                  r_valid <= 1'b1;
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  r_valid <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_valid <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign in_ready  = (r_state == S_IDLE) && !rst;
   assign busy      = (r_state == S_RUN);
   assign out_valid = r_valid;
   assign out       = r_out;
   assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_gf_red_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gf_red_seq
//  Description : Scoreboard bench for gf_red_seq (DATA_WIDTH=8, DIGIT=3).
//                Expected results come from a polynomial long-division model.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_gf_red_seq;

   localparam int DW    = 8;
   localparam int DIGIT = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  polyn_grade;
   logic [8:0]  polyn_red_in;
   logic [15:0] reduc_in;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out;
   logic        err;
   logic        busy;

   gf_red_seq #(.DATA_WIDTH(DW), .DIGIT(DIGIT)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .polyn_grade  (polyn_grade),
      .polyn_red_in (polyn_red_in),
      .reduc_in     (reduc_in),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out          (out),
      .err          (err),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic [7:0] out;
      logic       err;
      int         lat;
      int         acc;
   } exp_t;
   exp_t sb[$];

   int rdy_mode = 2;  // 0 random, 1 hold low, 2 hold high

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Remainder by schoolbook long division over GF(2).
   function automatic void model(input int k, input logic [8:0] m, input logic [15:0] v,
                                 output logic [7:0] o, output logic e, output int lat);
      logic [15:0] r;
      logic [15:0] mm;
      e = 1'b1;
      if (k >= 2 && k <= DW) e = ~m[4'(k)];
      o   = '0;
      lat = 0;
      if (!e) begin
         mm = 16'(m) & 16'((1 << (k + 1)) - 1);
         r  = v;
         for (int i = 15; i >= k; i--) begin
            if (r[4'(i)]) r = r ^ (mm << (i - k));
         end
         o   = r[7:0];
         lat = (2 * DW - k + DIGIT - 1) / DIGIT;
      end
   endfunction

   // Called at posedge+1; returns at posedge+1 after the accept edge.
   task automatic send(input int k, input logic [8:0] m, input logic [15:0] v,
                       input bit fixed, input logic [7:0] fo, input logic fe);
      exp_t x;
      int   w;
      model(k, m, v, x.out, x.err, x.lat);
      if (fixed) begin
         x.out = fo;
         x.err = fe;
      end
      w = 0;
      while (!in_ready && w < 200) begin
         @(posedge clk); #1;
         w++;
      end
      if (!in_ready) begin
         n_checks++;
         n_errors++;
         $display("FAIL accept_timeout: in_ready=%0b required 1", in_ready);
         return;
      end
      polyn_grade  = 4'(k);
      polyn_red_in = m;
      reduc_in     = v;
      in_valid     = 1'b1;
      @(posedge clk); #1;
      x.acc = cyc;
      sb.push_back(x);
      in_valid     = 1'b0;
      polyn_grade  = 4'($urandom_range(0, 15));
      polyn_red_in = 9'($urandom);
      reduc_in     = 16'($urandom);
   endtask

   task automatic drain();
      int w;
      w = 0;
      while (sb.size() != 0 && w < 300) begin
         @(posedge clk); #1;
         w++;
      end
      if (sb.size() != 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL result_timeout: %0d results outstanding, required 0", sb.size());
         sb.delete();
      end
   endtask

   // Consumer-side ready.
   always @(posedge clk) begin
      #2;
      if (rdy_mode == 0)      out_ready = 1'($urandom_range(0, 1));
      else                    out_ready = (rdy_mode == 2);
   end

   // Monitor: latency on rising valid, stability while held, data on take.
   logic       prev_v = 1'b0;
   logic [7:0] prev_o;
   logic       prev_e;
   always @(negedge clk) begin
      if (!rst && out_valid) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_valid: out_valid=1 required 0 (cycle %0d)", cyc);
         end else begin
            if (!prev_v) check("latency", 32'(cyc - sb[0].acc), 32'(sb[0].lat));
            else begin
               check("hold_out", 32'(out), 32'(prev_o));
               check("hold_err", 32'(err), 32'(prev_e));
            end
            check("in_ready_in_done", 32'(in_ready), 32'(0));
            if (out_ready) begin
               check("out", 32'(out), 32'(sb[0].out));
               check("err", 32'(err), 32'(sb[0].err));
               void'(sb.pop_front());
            end
         end
      end
      prev_v = out_valid && !out_ready && !rst;
      prev_o = out;
      prev_e = err;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      logic [8:0] m;
      int w;

      rst          = 1'b1;
      in_valid     = 1'b0;
      polyn_grade  = '0;
      polyn_red_in = '0;
      reduc_in     = '0;
      out_ready    = 1'b1;

      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", 32'(in_ready), 32'(0));
      check("rst_out_valid", 32'(out_valid), 32'(0));
      check("rst_out", 32'(out), 32'(0));
      check("rst_err", 32'(err), 32'(0));
      check("rst_busy", 32'(busy), 32'(0));
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      check("in_ready_after_rst", 32'(in_ready), 32'(1));

      // Directed vectors with known answers.
      send(8, 9'h11B, 16'h2B79, 1'b1, 8'hC1, 1'b0); drain();
      send(4, 9'h013, 16'h00FF, 1'b1, 8'h0D, 1'b0); drain();
      send(1, 9'h11B, 16'h1234, 1'b1, 8'h00, 1'b1); drain();
      send(8, 9'h01B, 16'h2B79, 1'b1, 8'h00, 1'b1); drain();
      send(0, 9'h1FF, 16'hFFFF, 1'b1, 8'h00, 1'b1); drain();
      send(9, 9'h1FF, 16'hFFFF, 1'b1, 8'h00, 1'b1); drain();
      // Boundaries: smallest degree, garbage above k, top bits set.
      send(2, 9'h007, 16'hFFFF, 1'b0, 8'h00, 1'b0); drain();
      send(4, 9'h1F3, 16'hA5C3, 1'b0, 8'h00, 1'b0); drain();
      send(8, 9'h11D, 16'h8000, 1'b0, 8'h00, 1'b0); drain();

      // Backpressure.
      rdy_mode = 1;
      send(8, 9'h11B, 16'($urandom), 1'b0, 8'h00, 1'b0);
      w = 0;
      while (!out_valid && w < 50) begin
         @(posedge clk); #1;
         w++;
      end
      check("bp_valid_seen", 32'(out_valid), 32'(1));
      repeat (5) begin
         @(posedge clk); #1;
         check("bp_valid_held", 32'(out_valid), 32'(1));
         check("bp_in_ready", 32'(in_ready), 32'(0));
      end
      rdy_mode = 2;
      @(posedge clk); #1;
      rdy_mode = 1;
      check("bp_valid_dropped", 32'(out_valid), 32'(0));
      check("bp_in_ready_back", 32'(in_ready), 32'(1));
      rdy_mode = 2;
      drain();

      // Reset in the third RUN cycle.
      send(4, 9'h013, 16'($urandom), 1'b0, 8'h00, 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("busy_before_rst", 32'(busy), 32'(1));
      rst = 1'b1;
      @(posedge clk); #1;
      sb.delete();
      check("abort_out_valid", 32'(out_valid), 32'(0));
      check("abort_busy", 32'(busy), 32'(0));
      rst = 1'b0;
      #1;
      check("abort_in_ready", 32'(in_ready), 32'(1));
      @(posedge clk); #1;
      send(8, 9'h11B, 16'h2B79, 1'b1, 8'hC1, 1'b0); drain();

      // Random traffic with random consumer backpressure.
      rdy_mode = 0;
      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(0, 7) == 0) k = $urandom_range(0, 15);
         else                           k = $urandom_range(2, 8);
         m = 9'($urandom);
         if (k <= 8 && $urandom_range(0, 7) != 0) m[4'(k)] = 1'b1;
         send(k, m, 16'($urandom), 1'b0, 8'h00, 1'b0);
      end
      drain();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
